// File: rtl/bextdep_issue_ctrl_pkg.sv
// Shared defaults and op encoding for the bext/bdep issue controller.
// Widths/latency here must match the largebextdep unit it drives.
package bextdep_issue_ctrl_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int TAG_W_DEF     = 4;
    localparam int LATENCY_DEF   = 2;
    localparam int OUT_DEPTH_DEF = 4;

    typedef enum logic {
        OP_BEXT = 1'b0,
        OP_BDEP = 1'b1
    } op_e;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bextdep_result_fifo.sv
// Synchronous result FIFO with occupancy count; depth need not be a power of 2.
// Ports: clk_i/rst_i, push_i+wdata_i, pop_i, rdata_o (head), empty_o, count_o.
module bextdep_result_fifo
    import bextdep_issue_ctrl_pkg::*;
#(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;

    assign full    = (cnt_q == FULL);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Upstream credits must make a push into a full FIFO impossible.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) begin
            assert (!full);
        end
    end

endmodule

// File: rtl/bextdep_issue_ctrl.sv
// Issue/retire stage in front of the fixed-latency largebextdep unit.
// Ports: req_* in (valid/ready), ex_* to unit, ex_rd back, res_* out (valid/ready).
module bextdep_issue_ctrl
    import bextdep_issue_ctrl_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int LATENCY   = LATENCY_DEF,
    parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_bdep,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             ex_bdep,
    output logic [XLEN-1:0]  ex_rs1,
    output logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_rd,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_rd,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_bdep
);

    localparam int CNT_W = cnt_width(OUT_DEPTH);
    localparam int ENT_W = XLEN + TAG_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(OUT_DEPTH);

    logic [LATENCY-1:0] pv_q;
    logic [LATENCY-1:0] pbdep_q;
    logic [TAG_W-1:0]   ptag_q [LATENCY];
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W:0]     used;
    logic               fire;
    logic               retire;
    logic               pop;
    logic               fifo_empty;
    logic [ENT_W-1:0]   fifo_rdata;

    // Credits come only from registered state, so req_ready never
    // depends on res_ready or req_valid in the same cycle.
    assign used      = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign req_ready = !reset && (used < DEPTH_L);
    assign fire      = req_valid && req_ready;
    assign retire    = pv_q[LATENCY-1];

    // Idle cycles feed zeros so the unit sees deterministic inputs.
    assign ex_bdep = fire ? req_bdep : OP_BEXT;
    assign ex_rs1  = fire ? req_rs1 : '0;
    assign ex_rs2  = fire ? req_rs2 : '0;

    always_comb begin
        inflight_d = inflight_q;
        if (fire && !retire) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!fire && retire) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pv_q       <= '0;
            pbdep_q    <= '0;
            inflight_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                ptag_q[i] <= '0;
            end
        end else begin
            pv_q[0]    <= fire;
            pbdep_q[0] <= req_bdep;
            ptag_q[0]  <= req_tag;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pbdep_q[i] <= pbdep_q[i-1];
                ptag_q[i]  <= ptag_q[i-1];
            end
            inflight_q <= inflight_d;
        end
    end

    assign res_valid = !reset && !fifo_empty;
    assign pop       = res_valid && res_ready;

    assign {res_rd, res_tag, res_bdep} = res_valid ? fifo_rdata : '0;

    bextdep_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (retire),
        .wdata_i ({ex_rd, ptag_q[LATENCY-1], pbdep_q[LATENCY-1]}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_bextdep_issue_ctrl.sv
// Directed bench for bextdep_issue_ctrl with a behavioural 2-cycle bext/bdep unit.
// Inputs are driven 1ns after the rising edge and outputs sampled before the next one.
module tb_bextdep_issue_ctrl;

    localparam int XLEN      = 32;
    localparam int TAG_W     = 4;
    localparam int LATENCY   = 2;
    localparam int OUT_DEPTH = 4;
    localparam int N_STREAM  = 200;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_bdep = 1'b0;
    logic [XLEN-1:0]  req_rs1 = '0;
    logic [XLEN-1:0]  req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             ex_bdep;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_rd;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [XLEN-1:0]  res_rd;
    logic [TAG_W-1:0] res_tag;
    logic             res_bdep;

    typedef struct packed {
        logic [XLEN-1:0]  rd;
        logic [TAG_W-1:0] tag;
        logic             bdep;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    bextdep_issue_ctrl #(
        .XLEN      (XLEN),
        .TAG_W     (TAG_W),
        .LATENCY   (LATENCY),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bdep  (req_bdep),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_tag   (req_tag),
        .ex_bdep   (ex_bdep),
        .ex_rs1    (ex_rs1),
        .ex_rs2    (ex_rs2),
        .ex_rd     (ex_rd),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_rd    (res_rd),
        .res_tag   (res_tag),
        .res_bdep  (res_bdep)
    );

    function automatic logic [XLEN-1:0] bext_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 0; i < XLEN; i++) begin
            if (m[i]) begin
                r[j] = a[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] bdep_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 0; i < XLEN; i++) begin
            if (m[i]) begin
                r[i] = a[j];
                j++;
            end
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic bd, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] m, input logic [TAG_W-1:0] tg);
        exp_t e;
        e.rd   = bd ? bdep_f(a, m) : bext_f(a, m);
        e.tag  = tg;
        e.bdep = bd;
        return e;
    endfunction

    // Behavioural largebextdep: operands in cycle n, rd valid in cycle n+2.
    logic [XLEN-1:0] u1_q = '0;
    logic [XLEN-1:0] u2_q = '0;
    always @(posedge clock) begin
        u1_q <= ex_bdep ? bdep_f(ex_rs1, ex_rs2) : bext_f(ex_rs1, ex_rs2);
        u2_q <= u1_q;
    end
    assign ex_rd = u2_q;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_bdep  = 1'b1;
        req_rs1   = 32'hFFFF_FFFF;
        req_rs2   = 32'hFFFF_FFFF;
        req_tag   = 4'hF;
        res_ready = 1'b1;
        repeat (3) next_cycle();
        #1;
        vectors++;
        if (req_ready !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: req_ready=%b res_valid=%b want 0/0", req_ready, res_valid);
        end
        vectors++;
        if (ex_rs1 !== '0 || ex_rs2 !== '0 || ex_bdep !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ex: ex=%h/%h/%b want 0/0/0", ex_rs1, ex_rs2, ex_bdep);
        end
        vectors++;
        if (res_rd !== '0 || res_tag !== '0 || res_bdep !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_res: res=%h/%h/%b want 0/0/0", res_rd, res_tag, res_bdep);
        end
        next_cycle();
        reset     = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_single(input string nm, input logic bd, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] m, input logic [TAG_W-1:0] tg,
                               input logic [XLEN-1:0] exp_rd);
        next_cycle();
        req_valid = 1'b1;
        req_bdep  = bd;
        req_rs1   = a;
        req_rs2   = m;
        req_tag   = tg;
        res_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || ex_rs1 !== a || ex_rs2 !== m || ex_bdep !== bd) begin
            miscompares++;
            $display("FAIL %s issue: ready=%b ex=%h/%h/%b want 1 %h/%h/%b",
                     nm, req_ready, ex_rs1, ex_rs2, ex_bdep, a, m, bd);
        end
        for (int k = 1; k <= LATENCY + 2; k++) begin
            next_cycle();
            req_valid = 1'b0;
            #1;
            vectors++;
            if (res_valid !== 1'(k == LATENCY + 1)) begin
                miscompares++;
                $display("FAIL %s latency: cycle %0d res_valid=%b want %b",
                         nm, k, res_valid, k == LATENCY + 1);
            end
            if (k == 1) begin
                vectors++;
                if (ex_rs1 !== '0 || ex_rs2 !== '0) begin
                    miscompares++;
                    $display("FAIL %s idle_ex: ex=%h/%h want 0/0", nm, ex_rs1, ex_rs2);
                end
            end
            if (k == LATENCY + 1) begin
                vectors++;
                if (res_rd !== exp_rd || res_tag !== tg || res_bdep !== bd) begin
                    miscompares++;
                    $display("FAIL %s result: got %h/%h/%b want %h/%h/%b",
                             nm, res_rd, res_tag, res_bdep, exp_rd, tg, bd);
                end
            end
        end
    endtask

    task automatic test_stream();
        exp_t e;
        int   n;
        n = 2 * N_STREAM;
        sb.delete();
        for (int i = 0; i < n + LATENCY + 1; i++) begin
            next_cycle();
            res_ready = 1'b1;
            req_valid = (i < n);
            if (i < n) begin
                req_bdep = (i >= N_STREAM);
                req_rs1  = $urandom;
                req_rs2  = $urandom;
                req_tag  = TAG_W'(i);
            end
            #1;
            if (i < n) begin
                vectors++;
                if (req_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_ready: cycle %0d req_ready=%b want 1", i, req_ready);
                end
                if (req_ready) sb.push_back(mk(req_bdep, req_rs1, req_rs2, req_tag));
            end
            vectors++;
            if (res_valid !== 1'(i >= LATENCY + 1)) begin
                miscompares++;
                $display("FAIL stream_bubble: cycle %0d res_valid=%b want %b",
                         i, res_valid, i >= LATENCY + 1);
            end
            if (res_valid && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({res_rd, res_tag, res_bdep} !== e) begin
                    miscompares++;
                    $display("FAIL stream_result: got %h/%h/%b want %h/%h/%b",
                             res_rd, res_tag, res_bdep, e.rd, e.tag, e.bdep);
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL stream_count: %0d results missing, want 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            req_valid = 1'b1;
            res_ready = 1'b0;
            req_bdep  = 1'b0;
            req_rs1   = 32'h0000_00F0 + 32'(i);
            req_rs2   = 32'h0000_00FF;
            req_tag   = TAG_W'(i);
            #1;
            vectors++;
            if (req_ready !== 1'(i < OUT_DEPTH)) begin
                miscompares++;
                $display("FAIL bp_accept: cycle %0d req_ready=%b want %b",
                         i, req_ready, i < OUT_DEPTH);
            end
            if (req_valid && req_ready) sb.push_back(mk(req_bdep, req_rs1, req_rs2, req_tag));
        end
        next_cycle();
        req_valid = 1'b1;
        res_ready = 1'b0;
        #1;
        vectors++;
        if (res_valid !== 1'b1 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: res_valid=%b req_ready=%b want 1/0", res_valid, req_ready);
        end
        res_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_comb_path: req_ready=%b want 0", req_ready);
        end
        e = sb.pop_front();
        vectors++;
        if ({res_rd, res_tag, res_bdep} !== e) begin
            miscompares++;
            $display("FAIL bp_first: got %h/%h/%b want %h/%h/%b",
                     res_rd, res_tag, res_bdep, e.rd, e.tag, e.bdep);
        end
        next_cycle();
        req_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_reopen: req_ready=%b want 1", req_ready);
        end
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            res_ready = 1'b1;
            #1;
            if (res_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra: unexpected tag %h", res_tag);
                end else begin
                    e = sb.pop_front();
                    if ({res_rd, res_tag, res_bdep} !== e) begin
                        miscompares++;
                        $display("FAIL bp_order: got %h/%h/%b want %h/%h/%b",
                                 res_rd, res_tag, res_bdep, e.rd, e.tag, e.bdep);
                    end
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL bp_drain: %0d results missing, want 0", sb.size());
        end
    endtask

    task automatic test_reset_midop();
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            req_valid = 1'b1;
            res_ready = (i == 3);
            req_bdep  = i[0];
            req_rs1   = 32'hA5A5_0000 + 32'(i);
            req_rs2   = 32'h0F0F_0F0F;
            req_tag   = TAG_W'(i + 8);
        end
        next_cycle();
        reset     = 1'b1;
        res_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0 || res_valid !== 1'b0 || res_rd !== '0) begin
            miscompares++;
            $display("FAIL midrst_cycle: req_ready=%b res_valid=%b res_rd=%h want 0/0/0",
                     req_ready, res_valid, res_rd);
        end
        next_cycle();
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        vectors++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after: res_valid=%b req_ready=%b want 0/1", res_valid, req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            #1;
            vectors++;
            if (res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_stale: cycle %0d res_valid=%b tag=%h want 0", i, res_valid, res_tag);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic rr;
        sb.delete();
        for (int c = 0; c < 1500 + 20; c++) begin
            next_cycle();
            req_valid = (c < 1500) ? 1'($urandom_range(0, 1)) : 1'b0;
            res_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : 1'b1;
            req_bdep  = 1'($urandom_range(0, 1));
            req_rs1   = $urandom;
            req_rs2   = $urandom;
            req_tag   = TAG_W'(c);
            #1;
            rr = req_ready;
            res_ready = !res_ready;
            #1;
            vectors++;
            if (req_ready !== rr) begin
                miscompares++;
                $display("FAIL rand_comb_path: cycle %0d req_ready=%b want %b", c, req_ready, rr);
            end
            res_ready = !res_ready;
            #1;
            if (req_valid && req_ready) sb.push_back(mk(req_bdep, req_rs1, req_rs2, req_tag));
            if (res_valid && res_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: unexpected tag %h", res_tag);
                end else begin
                    e = sb.pop_front();
                    if ({res_rd, res_tag, res_bdep} !== e) begin
                        miscompares++;
                        $display("FAIL rand_result: got %h/%h/%b want %h/%h/%b",
                                 res_rd, res_tag, res_bdep, e.rd, e.tag, e.bdep);
                    end
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain: %0d results missing, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single("bext", 1'b0, 32'h1234_5678, 32'h0000_FF00, 4'd3, 32'h0000_0056);
        test_single("bdep", 1'b1, 32'h0000_00AB, 32'hF0F0_0000, 4'd5, 32'hA0B0_0000);
        test_stream();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
